// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, exception codes and FSM states.
package mips_mem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [4:0] ADEL = 5'h04;
   localparam logic [4:0] ADES = 5'h05;
   localparam logic [4:0] DBE  = 5'h07;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mem_stage_hs_if.sv
// EXE-side, data-bus, WB-side and forwarding signals of the MEM stage.
interface mem_stage_hs_if #(
   parameter int unsigned DW     = 32,
   parameter int unsigned DES_W  = 7,
   parameter int unsigned CTRL_W = 32
);
   localparam int unsigned BE_W = DW / 8;

   logic              in_valid, in_ready, flush;
   logic              mem_rd, mem_wr, cp0_rd, mem_sext;
   logic [1:0]        mem_size;
   logic [DW-1:0]     alu_res, store_data, cp0_data, hilo_in, pc_in;
   logic [DES_W-1:0]  des_in;
   logic [1:0]        whilo_in;
   logic [CTRL_W-1:0] ctrl_in;

   logic              dreq, dwe, dack;
   logic [BE_W-1:0]   dbe;
   logic [DW-1:0]     daddr, dwdata, drdata;

   logic              out_valid, exc_valid;
   logic [DW-1:0]     result, hilo_out, bad_vaddr, exc_pc;
   logic [DES_W-1:0]  des_out;
   logic [1:0]        whilo_out;
   logic [CTRL_W-1:0] ctrl_out;
   logic [4:0]        exc_code;

   logic              fwd_valid, fwd_pending;
   logic [DES_W-1:0]  fwd_des;
   logic [DW-1:0]     fwd_result;

   // Environment side: EXE, data memory and WB/ID consumers
   modport master (
      output in_valid, flush, mem_rd, mem_wr, cp0_rd, mem_sext, mem_size,
             alu_res, store_data, cp0_data, hilo_in, pc_in, des_in, whilo_in, ctrl_in,
             dack, drdata,
      input  in_ready, dreq, dwe, dbe, daddr, dwdata,
             out_valid, result, hilo_out, des_out, whilo_out, ctrl_out,
             exc_valid, exc_code, bad_vaddr, exc_pc,
             fwd_valid, fwd_pending, fwd_des, fwd_result
   );

   // Stage side
   modport slave (
      input  in_valid, flush, mem_rd, mem_wr, cp0_rd, mem_sext, mem_size,
             alu_res, store_data, cp0_data, hilo_in, pc_in, des_in, whilo_in, ctrl_in,
             dack, drdata,
      output in_ready, dreq, dwe, dbe, daddr, dwdata,
             out_valid, result, hilo_out, des_out, whilo_out, ctrl_out,
             exc_valid, exc_code, bad_vaddr, exc_pc,
             fwd_valid, fwd_pending, fwd_des, fwd_result
   );
endinterface

// File: rtl/mem_align.sv
// Little-endian lane steering: alignment check, byte enables, store replication,
// load extraction with optional sign extension.
module mem_align
   import mips_mem_pkg::*;
#(
   parameter  int unsigned DW    = 32,
   localparam int unsigned BE_W  = DW / 8,
   localparam int unsigned OFF_W = $clog2(BE_W)
) (
   input  logic [1:0]       size,
   input  logic             sext,
   input  logic [OFF_W-1:0] off,
   input  logic [DW-1:0]    store_data,
   input  logic [DW-1:0]    rdata,
   output logic             misaligned,
   output logic [BE_W-1:0]  be,
   output logic [DW-1:0]    wdata,
   output logic [DW-1:0]    load_data
);

   logic [DW-1:0] shifted;

   always_comb begin
      misaligned = 1'b0;
      be         = '0;
      wdata      = '0;
      load_data  = '0;
      shifted    = rdata >> {off, 3'b000};
      case (size)
         SZ_B: begin
            be        = BE_W'(1) << off;
            wdata     = {BE_W{store_data[7:0]}};
            load_data = {{(DW-8){sext & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            misaligned = off[0];
            be         = BE_W'(3) << off;
            wdata      = {(BE_W/2){store_data[15:0]}};
            load_data  = {{(DW-16){sext & shifted[15]}}, shifted[15:0]};
         end
         // Word (and the unused 2'b11 encoding) spans the full bus
         default: begin
            misaligned = |off;
            be         = '1;
            wdata      = store_data;
            load_data  = shifted;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_hs.sv
// MIPS MEM stage on a variable-latency req/ack data bus, with alignment and
// bus-timeout exceptions, EXE back-pressure and forwarding to ID.
module mem_stage_hs
   import mips_mem_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned DES_W   = 7,
   parameter int unsigned CTRL_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input logic           clk,
   input logic           reset,
   mem_stage_hs_if.slave bus
);

   localparam int unsigned BE_W  = DW / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          state, next_state;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic            killed_q, killed_d;
   logic            dreq_c, complete, timeout;
   logic            is_mem, misaligned, discard, wb_now, exc_now, dreq_g;
   logic [BE_W-1:0] be;
   logic [DW-1:0]   wdata, load_data, res_mux;
   logic [4:0]      exc_code_c;

   mem_align #(.DW(DW)) u_align (
      .size       (bus.mem_size),
      .sext       (bus.mem_sext),
      .off        (bus.alu_res[OFF_W-1:0]),
      .store_data (bus.store_data),
      .rdata      (bus.drdata),
      .misaligned (misaligned),
      .be         (be),
      .wdata      (wdata),
      .load_data  (load_data)
   );

   assign is_mem  = bus.mem_rd | bus.mem_wr;
   assign res_mux = bus.cp0_rd ? bus.cp0_data : (bus.mem_rd ? load_data : bus.alu_res);

   // A flush seen at any point of a bus access kills its writeback
   assign discard = bus.flush | killed_q;
   assign wb_now  = complete & ~discard;
   assign exc_now = wb_now & (timeout | ((state == S_IDLE) & is_mem & misaligned));
   assign exc_code_c = timeout ? DBE : (bus.mem_rd ? ADEL : ADES);

   // Next-state, bus request and completion decode
   always_comb begin
      next_state = state;
      cnt_d      = cnt;
      killed_d   = killed_q;
      dreq_c     = 1'b0;
      complete   = 1'b0;
      timeout    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (bus.flush || !is_mem || misaligned) begin
                  complete = 1'b1;
               end else begin
                  dreq_c = 1'b1;
                  if (bus.dack) begin
                     complete = 1'b1;
                  end else begin
                     next_state = S_BUSY;
                     cnt_d      = '0;
                  end
               end
            end
         end
         S_BUSY: begin
            if (bus.flush) killed_d = 1'b1;
            // The IDLE request cycle plus TIMEOUT-1 BUSY cycles give TIMEOUT dreq cycles
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
               timeout    = 1'b1;
               complete   = 1'b1;
               next_state = S_IDLE;
            end else begin
               dreq_c = 1'b1;
               if (bus.dack) begin
                  complete   = 1'b1;
                  next_state = S_IDLE;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
         end
         default: next_state = S_IDLE;
      endcase
      if (complete) killed_d = 1'b0;
   end

   // State, timeout counter and WB output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         killed_q      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         bus.hilo_out  <= '0;
         bus.des_out   <= '0;
         bus.whilo_out <= '0;
         bus.ctrl_out  <= '0;
         bus.exc_valid <= 1'b0;
         bus.exc_code  <= '0;
         bus.bad_vaddr <= '0;
         bus.exc_pc    <= '0;
      end else begin
         state         <= next_state;
         cnt           <= cnt_d;
         killed_q      <= killed_d;
         bus.out_valid <= wb_now;
         bus.exc_valid <= exc_now;
         if (wb_now) begin
            bus.result    <= res_mux;
            bus.hilo_out  <= bus.hilo_in;
            bus.des_out   <= exc_now ? '0 : bus.des_in;
            bus.whilo_out <= exc_now ? '0 : bus.whilo_in;
            bus.ctrl_out  <= exc_now ? '0 : bus.ctrl_in;
            bus.exc_code  <= exc_now ? exc_code_c : '0;
            bus.bad_vaddr <= exc_now ? bus.alu_res : '0;
            bus.exc_pc    <= exc_now ? bus.pc_in : '0;
         end
      end
   end

   // Combinational outputs are forced quiet while reset is held
   assign dreq_g          = ~reset & dreq_c;
   assign bus.dreq        = dreq_g;
   assign bus.dwe         = dreq_g & bus.mem_wr;
   assign bus.daddr       = dreq_g ? bus.alu_res : '0;
   assign bus.dbe         = dreq_g ? be : '0;
   assign bus.dwdata      = dreq_g ? wdata : '0;
   assign bus.in_ready    = ~reset & (complete | ((state == S_IDLE) & ~bus.in_valid));
   assign bus.fwd_valid   = ~reset & wb_now & ~exc_now;
   assign bus.fwd_pending = ~reset & bus.in_valid & bus.mem_rd & ~complete;
   assign bus.fwd_des     = (~reset & bus.in_valid) ? bus.des_in : '0;
   assign bus.fwd_result  = reset ? '0 : res_mux;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: ALU pass-through, loads/stores with lane steering,
// alignment and timeout exceptions, flush handling and reset during a bus access.
module tb_mem_stage_hs;
   import mips_mem_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_stage_hs_if #(.DW(32), .DES_W(7), .CTRL_W(32)) bus ();

   mem_stage_hs #(.DW(32), .DES_W(7), .CTRL_W(32), .TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.in_valid = 0; bus.flush = 0; bus.mem_rd = 0; bus.mem_wr = 0; bus.cp0_rd = 0;
      bus.mem_sext = 0; bus.mem_size = SZ_W; bus.alu_res = 0; bus.store_data = 0;
      bus.cp0_data = 0; bus.hilo_in = 0; bus.pc_in = 0; bus.des_in = 0; bus.whilo_in = 0;
      bus.ctrl_in = 0; bus.dack = 0; bus.drdata = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_in();
      bus.in_valid = 1; bus.mem_rd = 1; bus.alu_res = 32'h100; bus.des_in = 7'd3;
      repeat (2) step();
      n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL rst_dreq: got %b exp 0", bus.dreq); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b exp 0", bus.in_ready); end
      n_cmp++; if (bus.fwd_des !== 7'd0) begin n_err++; $display("FAIL rst_fwd_des: got %h exp 0", bus.fwd_des); end
      n_cmp++; if (bus.fwd_pending !== 1'b0) begin n_err++; $display("FAIL rst_fwd_pending: got %b exp 0", bus.fwd_pending); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); end
      n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h exp 0", bus.result); end
      n_cmp++; if (bus.exc_valid !== 1'b0) begin n_err++; $display("FAIL rst_exc_valid: got %b exp 0", bus.exc_valid); end
      n_cmp++; if (bus.exc_code !== 5'h0) begin n_err++; $display("FAIL rst_exc_code: got %h exp 0", bus.exc_code); end
      n_cmp++; if (bus.des_out !== 7'd0) begin n_err++; $display("FAIL rst_des_out: got %h exp 0", bus.des_out); end
      clear_in();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_alu();
      bus.in_valid = 1; bus.alu_res = 32'h1234_5678; bus.des_in = 7'd5;
      bus.ctrl_in = 32'hA5; bus.hilo_in = 32'h55; bus.whilo_in = 2'b10;
      #1;
      n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL alu_dreq: got %b exp 0", bus.dreq); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL alu_in_ready: got %b exp 1", bus.in_ready); end
      n_cmp++; if (bus.fwd_valid !== 1'b1) begin n_err++; $display("FAIL alu_fwd_valid: got %b exp 1", bus.fwd_valid); end
      n_cmp++; if (bus.fwd_des !== 7'd5) begin n_err++; $display("FAIL alu_fwd_des: got %h exp 5", bus.fwd_des); end
      n_cmp++; if (bus.fwd_result !== 32'h1234_5678) begin n_err++; $display("FAIL alu_fwd_result: got %h exp 12345678", bus.fwd_result); end
      step();
      clear_in();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL alu_out_valid: got %b exp 1", bus.out_valid); end
      n_cmp++; if (bus.result !== 32'h1234_5678) begin n_err++; $display("FAIL alu_result: got %h exp 12345678", bus.result); end
      n_cmp++; if (bus.des_out !== 7'd5) begin n_err++; $display("FAIL alu_des_out: got %h exp 5", bus.des_out); end
      n_cmp++; if (bus.ctrl_out !== 32'hA5) begin n_err++; $display("FAIL alu_ctrl_out: got %h exp a5", bus.ctrl_out); end
      n_cmp++; if (bus.hilo_out !== 32'h55) begin n_err++; $display("FAIL alu_hilo_out: got %h exp 55", bus.hilo_out); end
      n_cmp++; if (bus.whilo_out !== 2'b10) begin n_err++; $display("FAIL alu_whilo_out: got %b exp 10", bus.whilo_out); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL alu_pulse: got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_loads();
      logic [31:0] addr [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1004, 32'h1001};
      logic [1:0]  size [6] = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_W, SZ_B};
      logic        sext [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] rdat [6] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h80FF_1234, 32'h80FF_9234,
                                32'hDEAD_BEEF, 32'h0000_7F00};
      logic [31:0] expv [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_9234,
                                32'hDEAD_BEEF, 32'h0000_007F};
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1; bus.mem_rd = 1; bus.alu_res = addr[i]; bus.mem_size = size[i];
         bus.mem_sext = sext[i]; bus.drdata = rdat[i]; bus.dack = 1; bus.des_in = 7'd3;
         #1;
         n_cmp++; if (bus.dreq !== 1'b1) begin n_err++; $display("FAIL ld%0d_dreq: got %b exp 1", i, bus.dreq); end
         n_cmp++; if (bus.dwe !== 1'b0) begin n_err++; $display("FAIL ld%0d_dwe: got %b exp 0", i, bus.dwe); end
         n_cmp++; if (bus.daddr !== addr[i]) begin n_err++; $display("FAIL ld%0d_daddr: got %h exp %h", i, bus.daddr, addr[i]); end
         n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ld%0d_in_ready: got %b exp 1", i, bus.in_ready); end
         n_cmp++; if (bus.fwd_pending !== 1'b0) begin n_err++; $display("FAIL ld%0d_fwd_pending: got %b exp 0", i, bus.fwd_pending); end
         n_cmp++; if (bus.fwd_result !== expv[i]) begin n_err++; $display("FAIL ld%0d_fwd_result: got %h exp %h", i, bus.fwd_result, expv[i]); end
         step();
         clear_in();
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ld%0d_out_valid: got %b exp 1", i, bus.out_valid); end
         n_cmp++; if (bus.result !== expv[i]) begin n_err++; $display("FAIL ld%0d_result: got %h exp %h", i, bus.result, expv[i]); end
      end
   endtask

   task automatic test_stores();
      logic [31:0] addr [3] = '{32'h0001, 32'h3000, 32'h2000};
      logic [1:0]  size [3] = '{SZ_B, SZ_W, SZ_H};
      logic [31:0] sdat [3] = '{32'hFFFF_FF12, 32'hCAFE_F00D, 32'h5555_1234};
      logic [3:0]  ebe  [3] = '{4'b0010, 4'b1111, 4'b0011};
      logic [31:0] ewd  [3] = '{32'h1212_1212, 32'hCAFE_F00D, 32'h1234_1234};
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1; bus.mem_wr = 1; bus.alu_res = addr[i]; bus.mem_size = size[i];
         bus.store_data = sdat[i]; bus.dack = 1;
         #1;
         n_cmp++; if (bus.dwe !== 1'b1) begin n_err++; $display("FAIL st%0d_dwe: got %b exp 1", i, bus.dwe); end
         n_cmp++; if (bus.dbe !== ebe[i]) begin n_err++; $display("FAIL st%0d_dbe: got %b exp %b", i, bus.dbe, ebe[i]); end
         n_cmp++; if (bus.dwdata !== ewd[i]) begin n_err++; $display("FAIL st%0d_dwdata: got %h exp %h", i, bus.dwdata, ewd[i]); end
         step();
         clear_in();
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL st%0d_out_valid: got %b exp 1", i, bus.out_valid); end
      end
   endtask

   task automatic test_sh_wait();
      bus.in_valid = 1; bus.mem_wr = 1; bus.mem_size = SZ_H; bus.alu_res = 32'h2002;
      bus.store_data = 32'h0000_ABCD; bus.des_in = 7'd0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL sh_c%0d_in_ready: got %b exp 0", c, bus.in_ready); end
         n_cmp++; if (bus.dreq !== 1'b1) begin n_err++; $display("FAIL sh_c%0d_dreq: got %b exp 1", c, bus.dreq); end
         n_cmp++; if (bus.dbe !== 4'b1100) begin n_err++; $display("FAIL sh_c%0d_dbe: got %b exp 1100", c, bus.dbe); end
         n_cmp++; if (bus.dwdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_c%0d_dwdata: got %h exp abcdabcd", c, bus.dwdata); end
         n_cmp++; if (bus.fwd_pending !== 1'b0) begin n_err++; $display("FAIL sh_c%0d_fwd_pending: got %b exp 0", c, bus.fwd_pending); end
         step();
      end
      bus.dack = 1;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL sh_ack_in_ready: got %b exp 1", bus.in_ready); end
      n_cmp++; if (bus.fwd_pending !== 1'b0) begin n_err++; $display("FAIL sh_ack_fwd_pending: got %b exp 0", bus.fwd_pending); end
      step();
      clear_in();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sh_out_valid: got %b exp 1", bus.out_valid); end
      #1;
      n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL sh_idle_dreq: got %b exp 0", bus.dreq); end
   endtask

   task automatic test_misalign();
      bus.in_valid = 1; bus.mem_rd = 1; bus.mem_size = SZ_W; bus.alu_res = 32'h1;
      bus.pc_in = 32'h400; bus.des_in = 7'd9;
      #1;
      n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL adel_dreq: got %b exp 0", bus.dreq); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL adel_in_ready: got %b exp 1", bus.in_ready); end
      n_cmp++; if (bus.fwd_valid !== 1'b0) begin n_err++; $display("FAIL adel_fwd_valid: got %b exp 0", bus.fwd_valid); end
      step();
      clear_in();
      n_cmp++; if (bus.exc_valid !== 1'b1) begin n_err++; $display("FAIL adel_exc_valid: got %b exp 1", bus.exc_valid); end
      n_cmp++; if (bus.exc_code !== 5'h04) begin n_err++; $display("FAIL adel_exc_code: got %h exp 04", bus.exc_code); end
      n_cmp++; if (bus.bad_vaddr !== 32'h1) begin n_err++; $display("FAIL adel_bad_vaddr: got %h exp 1", bus.bad_vaddr); end
      n_cmp++; if (bus.exc_pc !== 32'h400) begin n_err++; $display("FAIL adel_exc_pc: got %h exp 400", bus.exc_pc); end
      n_cmp++; if (bus.des_out !== 7'd0) begin n_err++; $display("FAIL adel_des_out: got %h exp 0", bus.des_out); end
      // Halfword store on an odd address
      bus.in_valid = 1; bus.mem_wr = 1; bus.mem_size = SZ_H; bus.alu_res = 32'h3; bus.pc_in = 32'h404;
      #1;
      n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL ades_dreq: got %b exp 0", bus.dreq); end
      step();
      clear_in();
      n_cmp++; if (bus.exc_code !== 5'h05) begin n_err++; $display("FAIL ades_exc_code: got %h exp 05", bus.exc_code); end
      n_cmp++; if (bus.exc_pc !== 32'h404) begin n_err++; $display("FAIL ades_exc_pc: got %h exp 404", bus.exc_pc); end
      step();
      n_cmp++; if (bus.exc_valid !== 1'b0) begin n_err++; $display("FAIL exc_pulse: got %b exp 0", bus.exc_valid); end
   endtask

   task automatic test_timeout();
      int  n_dreq = 0;
      bit  done = 0;
      bus.in_valid = 1; bus.mem_rd = 1; bus.mem_size = SZ_W; bus.alu_res = 32'h100;
      bus.des_in = 7'd4; bus.pc_in = 32'h800;
      #1;
      for (int c = 0; c < 20 && !done; c++) begin
         if (bus.in_ready) begin
            done = 1;
            n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL to_end_dreq: got %b exp 0", bus.dreq); end
            n_cmp++; if (bus.fwd_pending !== 1'b0) begin n_err++; $display("FAIL to_end_fwd_pending: got %b exp 0", bus.fwd_pending); end
         end else begin
            if (bus.dreq) n_dreq++;
            n_cmp++; if (bus.fwd_pending !== 1'b1) begin n_err++; $display("FAIL to_c%0d_fwd_pending: got %b exp 1", c, bus.fwd_pending); end
            step();
            #1;
         end
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL to_complete: got %b exp 1 within 20 cycles", done); end
      n_cmp++; if (n_dreq !== 4) begin n_err++; $display("FAIL to_dreq_cycles: got %0d exp 4", n_dreq); end
      step();
      clear_in();
      n_cmp++; if (bus.exc_valid !== 1'b1) begin n_err++; $display("FAIL to_exc_valid: got %b exp 1", bus.exc_valid); end
      n_cmp++; if (bus.exc_code !== 5'h07) begin n_err++; $display("FAIL to_exc_code: got %h exp 07", bus.exc_code); end
      n_cmp++; if (bus.bad_vaddr !== 32'h100) begin n_err++; $display("FAIL to_bad_vaddr: got %h exp 100", bus.bad_vaddr); end
      n_cmp++; if (bus.des_out !== 7'd0) begin n_err++; $display("FAIL to_des_out: got %h exp 0", bus.des_out); end
   endtask

   task automatic test_flush();
      // Flush in IDLE: no bus access, nothing written back
      bus.in_valid = 1; bus.mem_rd = 1; bus.alu_res = 32'h40; bus.flush = 1; bus.des_in = 7'd6;
      #1;
      n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL fli_dreq: got %b exp 0", bus.dreq); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fli_in_ready: got %b exp 1", bus.in_ready); end
      step();
      clear_in();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fli_out_valid: got %b exp 0", bus.out_valid); end
      // Flush while BUSY: request held until the ack, result dropped
      bus.in_valid = 1; bus.mem_rd = 1; bus.alu_res = 32'h200; bus.des_in = 7'd7;
      step();
      bus.flush = 1;
      #1;
      n_cmp++; if (bus.dreq !== 1'b1) begin n_err++; $display("FAIL flb_c1_dreq: got %b exp 1", bus.dreq); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flb_c1_in_ready: got %b exp 0", bus.in_ready); end
      step();
      bus.flush = 0;
      #1;
      n_cmp++; if (bus.dreq !== 1'b1) begin n_err++; $display("FAIL flb_c2_dreq: got %b exp 1", bus.dreq); end
      step();
      bus.dack = 1; bus.drdata = 32'hFEED_0001;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flb_ack_in_ready: got %b exp 1", bus.in_ready); end
      n_cmp++; if (bus.fwd_valid !== 1'b0) begin n_err++; $display("FAIL flb_ack_fwd_valid: got %b exp 0", bus.fwd_valid); end
      step();
      clear_in();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flb_out_valid: got %b exp 0", bus.out_valid); end
      n_cmp++; if (bus.exc_valid !== 1'b0) begin n_err++; $display("FAIL flb_exc_valid: got %b exp 0", bus.exc_valid); end
   endtask

   task automatic test_back_to_back();
      bus.in_valid = 1; bus.alu_res = 32'h11; bus.des_in = 7'd1;
      step();
      bus.alu_res = 32'h22; bus.des_in = 7'd2;
      n_cmp++; if (bus.result !== 32'h11) begin n_err++; $display("FAIL b2b_first_result: got %h exp 11", bus.result); end
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b exp 1", bus.in_ready); end
      step();
      bus.cp0_rd = 1; bus.cp0_data = 32'hC0C0; bus.alu_res = 32'h1; bus.des_in = 7'd8;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %b exp 1", bus.out_valid); end
      n_cmp++; if (bus.result !== 32'h22) begin n_err++; $display("FAIL b2b_second_result: got %h exp 22", bus.result); end
      n_cmp++; if (bus.des_out !== 7'd2) begin n_err++; $display("FAIL b2b_second_des: got %h exp 2", bus.des_out); end
      #1;
      n_cmp++; if (bus.fwd_result !== 32'hC0C0) begin n_err++; $display("FAIL cp0_fwd_result: got %h exp c0c0", bus.fwd_result); end
      step();
      clear_in();
      n_cmp++; if (bus.result !== 32'hC0C0) begin n_err++; $display("FAIL cp0_result: got %h exp c0c0", bus.result); end
      step();
   endtask

   task automatic test_reset_busy();
      bus.in_valid = 1; bus.mem_rd = 1; bus.alu_res = 32'h300; bus.des_in = 7'd5;
      step();
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.dreq !== 1'b0) begin n_err++; $display("FAIL rb_dreq: got %b exp 0", bus.dreq); end
      step();
      clear_in();
      reset = 1'b0;
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rb_out_valid: got %b exp 0", bus.out_valid); end
      bus.in_valid = 1; bus.mem_rd = 1; bus.alu_res = 32'h304; bus.dack = 1; bus.drdata = 32'h7777;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rb_idle_in_ready: got %b exp 1", bus.in_ready); end
      step();
      clear_in();
      n_cmp++; if (bus.result !== 32'h7777) begin n_err++; $display("FAIL rb_result: got %h exp 7777", bus.result); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_stores();
      test_sh_wait();
      test_misalign();
      test_timeout();
      test_flush();
      test_back_to_back();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
